// File: rtl/mbox_req_seq.sv
// MBOX request sequencer: arbitrates EBOX and pager-fill requests onto the single cache/MBOX port,
// with retry backoff and sticky error flags. Optional response watchdog under `MCL_TIMEOUT_EN`.
module mbox_req_seq #(
    parameter int ADDR_W      = 22,
    parameter int RETRY_GAP   = 4,
    parameter int MAX_RETRY   = 15,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              eboxReq,
    input  logic              eboxWrite,
    input  logic [ADDR_W-1:0] eboxAddr,
    input  logic              pfReq,
    input  logic [ADDR_W-1:0] pfAddr,
    input  logic              cshEBOXT0,
    input  logic              cshEBOXRetry,
    input  logic              mboxRespIn,
    output logic              mboxReq,
    output logic              mboxWrite,
    output logic [ADDR_W-1:0] mboxAddr,
    output logic              mboxSrc,
    output logic              eboxAck,
    output logic              eboxSync,
    output logic              pfAck,
    output logic              pfHold,
    output logic              busy,
    output logic              retryErr,
    output logic              timeoutErr
);
    localparam int RC_W  = $clog2(MAX_RETRY + 1);
    localparam int GAP_W = $clog2(RETRY_GAP + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, BACKOFF, DONE} state_t;

    state_t             state;
    logic               lastPf;
    logic [RC_W-1:0]    retryCnt;
    logic [GAP_W-1:0]   gapCnt;
    logic               grantPf;
    logic               grantEbox;
    logic               toExpire;
    logic               goDone;
    logic               goRetry;

    // Alternate owners when both requesters contend: PF yields only if it went last.
    always_comb begin
        grantPf   = (state == IDLE) && pfReq && !(eboxReq && lastPf);
        grantEbox = (state == IDLE) && !grantPf && eboxReq;
        // A response (or watchdog expiry) beats a same-cycle retry.
        goDone    = ((state == WAIT) && mboxRespIn) || toExpire;
        goRetry   = !goDone && cshEBOXRetry && ((state == REQ) || (state == WAIT));
    end

    assign pfHold = eboxReq && busy && mboxSrc;

`ifdef MCL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] toCnt;
    logic            enterReq;

    assign enterReq = grantPf || grantEbox || ((state == BACKOFF) && (gapCnt == '0));
    assign toExpire = ((state == REQ) || (state == WAIT)) && (toCnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            toCnt      <= '0;
            timeoutErr <= 1'b0;
        end else begin
            if (enterReq)
                toCnt <= '0;
            else if ((state == REQ) || (state == WAIT))
                toCnt <= toCnt + 1'b1;
            if (toExpire)
                timeoutErr <= 1'b1;
        end
    end
`else
    assign toExpire   = 1'b0;
    assign timeoutErr = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            lastPf    <= 1'b0;
            retryCnt  <= '0;
            gapCnt    <= '0;
            mboxReq   <= 1'b0;
            mboxWrite <= 1'b0;
            mboxAddr  <= '0;
            mboxSrc   <= 1'b0;
            eboxAck   <= 1'b0;
            eboxSync  <= 1'b0;
            pfAck     <= 1'b0;
            busy      <= 1'b0;
            retryErr  <= 1'b0;
        end else begin
            eboxAck  <= 1'b0;
            eboxSync <= 1'b0;
            pfAck    <= 1'b0;
            if (goDone) begin
                state    <= DONE;
                mboxReq  <= 1'b0;
                eboxAck  <= !mboxSrc;
                eboxSync <= !mboxSrc;
                pfAck    <= mboxSrc;
            end else if (goRetry) begin
                state   <= BACKOFF;
                mboxReq <= 1'b0;
                gapCnt  <= GAP_W'(RETRY_GAP - 1);
                if (retryCnt == RC_W'(MAX_RETRY))
                    retryErr <= 1'b1;
                else
                    retryCnt <= retryCnt + 1'b1;
            end else begin
                case (state)
                    IDLE: if (grantPf || grantEbox) begin
                        state     <= REQ;
                        mboxReq   <= 1'b1;
                        busy      <= 1'b1;
                        mboxSrc   <= grantPf;
                        lastPf    <= grantPf;
                        mboxAddr  <= grantPf ? pfAddr : eboxAddr;
                        mboxWrite <= grantPf ? 1'b0 : eboxWrite;
                        retryCnt  <= '0;
                    end
                    REQ: if (cshEBOXT0) begin
                        state   <= WAIT;
                        mboxReq <= 1'b0;
                    end
                    BACKOFF: if (gapCnt == '0) begin
                        state   <= REQ;
                        mboxReq <= 1'b1;
                    end else begin
                        gapCnt <= gapCnt - 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mbox_req_seq.sv
// Directed bench for mbox_req_seq: arbitration, alternation, retry backoff/saturation,
// response-vs-retry priority, reset abort and (under MCL_TIMEOUT_EN) the watchdog.
module tb_mbox_req_seq;
    localparam int ADDR_W = 22;

    logic              clk = 1'b0;
    logic              resetN;
    logic              eboxReq, eboxWrite, pfReq;
    logic [ADDR_W-1:0] eboxAddr, pfAddr;
    logic              cshEBOXT0, cshEBOXRetry, mboxRespIn;
    logic              mboxReq, mboxWrite, mboxSrc;
    logic [ADDR_W-1:0] mboxAddr;
    logic              eboxAck, eboxSync, pfAck, pfHold, busy, retryErr, timeoutErr;

    int vectors = 0;
    int fails   = 0;

    mbox_req_seq #(
        .ADDR_W(ADDR_W), .RETRY_GAP(4), .MAX_RETRY(15), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .resetN(resetN),
        .eboxReq(eboxReq), .eboxWrite(eboxWrite), .eboxAddr(eboxAddr),
        .pfReq(pfReq), .pfAddr(pfAddr),
        .cshEBOXT0(cshEBOXT0), .cshEBOXRetry(cshEBOXRetry), .mboxRespIn(mboxRespIn),
        .mboxReq(mboxReq), .mboxWrite(mboxWrite), .mboxAddr(mboxAddr), .mboxSrc(mboxSrc),
        .eboxAck(eboxAck), .eboxSync(eboxSync), .pfAck(pfAck), .pfHold(pfHold),
        .busy(busy), .retryErr(retryErr), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // T0 on the REQ cycle, response on the WAIT cycle, then check the ack pulse.
    task automatic doneTxn(input string tag, input logic expPf);
        cshEBOXT0 = 1'b1; tick(); cshEBOXT0 = 1'b0;
        check({tag, " wait req"}, 32'(mboxReq), 32'd0);
        check({tag, " wait busy"}, 32'(busy), 32'd1);
        mboxRespIn = 1'b1; tick(); mboxRespIn = 1'b0;
        check({tag, " eboxAck"}, 32'(eboxAck), 32'(!expPf));
        check({tag, " eboxSync"}, 32'(eboxSync), 32'(!expPf));
        check({tag, " pfAck"}, 32'(pfAck), 32'(expPf));
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " req"}, 32'(mboxReq), 32'd0);
        check({tag, " addr"}, 32'(mboxAddr), 32'd0);
        check({tag, " flags"},
              32'({mboxWrite, mboxSrc, eboxAck, eboxSync, pfAck, pfHold, busy, retryErr, timeoutErr}),
              32'd0);
    endtask

    initial begin
        resetN = 1'b0; eboxReq = 1'b0; eboxWrite = 1'b0; eboxAddr = '0;
        pfReq = 1'b0; pfAddr = '0; cshEBOXT0 = 1'b0; cshEBOXRetry = 1'b0; mboxRespIn = 1'b0;
        tick(); tick();
        checkAllZero("reset");
        resetN = 1'b1;
        tick();

        // Basic EBOX read; input address change mid-transaction must not leak through.
        eboxReq = 1'b1; eboxAddr = 22'h1234; eboxWrite = 1'b0;
        tick();
        check("ebox grant req", 32'(mboxReq), 32'd1);
        check("ebox grant addr", 32'(mboxAddr), 32'h1234);
        check("ebox grant src", 32'(mboxSrc), 32'd0);
        eboxAddr = 22'h3FFFF;
        doneTxn("ebox rd", 1'b0);
        check("ebox addr held", 32'(mboxAddr), 32'h1234);
        eboxReq = 1'b0;
        tick();
        check("ebox idle busy", 32'(busy), 32'd0);
        check("ebox ack 1cyc", 32'(eboxAck), 32'd0);

        // Contention from IDLE with lastPf=0: PF first, EBOX held off.
        eboxReq = 1'b1; eboxAddr = 22'h0ABC; pfReq = 1'b1; pfAddr = 22'h2F00;
        tick();
        check("pf first src", 32'(mboxSrc), 32'd1);
        check("pf first addr", 32'(mboxAddr), 32'h2F00);
        check("pfHold", 32'(pfHold), 32'd1);
        doneTxn("pf1", 1'b1);
        pfReq = 1'b0; tick();
        // Second PF request arrives while EBOX still waiting: EBOX must win now.
        pfReq = 1'b1; pfAddr = 22'h2F40;
        tick();
        check("alt ebox src", 32'(mboxSrc), 32'd0);
        check("alt ebox addr", 32'(mboxAddr), 32'h0ABC);
        check("pfHold ebox owner", 32'(pfHold), 32'd0);
        doneTxn("alt ebox", 1'b0);
        eboxReq = 1'b0; tick();
        tick();
        check("alt pf src", 32'(mboxSrc), 32'd1);
        check("alt pf addr", 32'(mboxAddr), 32'h2F40);
        check("pfHold no ebox", 32'(pfHold), 32'd0);
        doneTxn("alt pf", 1'b1);
        pfReq = 1'b0; tick();

        // Retry in WAIT: four cycles low, then same address re-issued.
        eboxReq = 1'b1; eboxAddr = 22'h02AA; eboxWrite = 1'b1;
        tick();
        check("retry write", 32'(mboxWrite), 32'd1);
        cshEBOXT0 = 1'b1; tick(); cshEBOXT0 = 1'b0;
        cshEBOXRetry = 1'b1; tick(); cshEBOXRetry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("backoff low %0d", i), 32'(mboxReq), 32'd0);
            tick();
        end
        check("reissue req", 32'(mboxReq), 32'd1);
        check("reissue addr", 32'(mboxAddr), 32'h02AA);
        // Retries 2..16 from REQ; the 16th saturates.
        for (int r = 2; r <= 16; r++) begin
            cshEBOXRetry = 1'b1; tick(); cshEBOXRetry = 1'b0;
            if (r == 15) check("retryErr at 15", 32'(retryErr), 32'd0);
            tick(); tick(); tick(); tick();
        end
        check("retryErr at 16", 32'(retryErr), 32'd1);
        check("reissue after sat", 32'(mboxReq), 32'd1);
        doneTxn("retry txn", 1'b0);
        eboxReq = 1'b0; eboxWrite = 1'b0; tick();
        check("retryErr sticky", 32'(retryErr), 32'd1);

        // Response and retry together: ack next cycle, no backoff.
        eboxReq = 1'b1; eboxAddr = 22'h0777;
        tick();
        cshEBOXT0 = 1'b1; tick(); cshEBOXT0 = 1'b0;
        mboxRespIn = 1'b1; cshEBOXRetry = 1'b1; tick();
        mboxRespIn = 1'b0; cshEBOXRetry = 1'b0;
        check("resp wins ack", 32'(eboxAck), 32'd1);
        eboxReq = 1'b0; tick();
        check("resp wins idle", 32'(busy), 32'd0);

        // Reset while in WAIT aborts without ack.
        eboxReq = 1'b1; eboxAddr = 22'h0555;
        tick();
        cshEBOXT0 = 1'b1; tick(); cshEBOXT0 = 1'b0;
        resetN = 1'b0; #1;
        checkAllZero("mid reset");
        mboxRespIn = 1'b1; tick(); mboxRespIn = 1'b0;
        check("mid reset no ack", 32'(eboxAck), 32'd0);
        eboxReq = 1'b0; resetN = 1'b1; tick();

`ifdef MCL_TIMEOUT_EN
        // Watchdog: 8 cycles in REQ with no T0, then forced completion.
        eboxReq = 1'b1; eboxAddr = 22'h0100;
        tick();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("to pending %0d", i), 32'({eboxAck, timeoutErr}), 32'd0);
            tick();
        end
        tick();
        check("to ack", 32'(eboxAck), 32'd1);
        check("to err", 32'(timeoutErr), 32'd1);
        eboxReq = 1'b0; tick();
`else
        check("timeoutErr tied", 32'(timeoutErr), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
